// File: rtl/micon_uart_pkg.sv
// ---------------------------------------------------------------------------
// micon_uart_pkg
// Shared types and constants for the UART transmit path.
//   uart_tx_state_t : frame FSM encoding (IDLE, START, DATA, STOP)
//   UART_DATA_BITS  : payload bits per frame
//   UART_FRAME_BITS : start + payload + stop bits per frame
// ---------------------------------------------------------------------------
package micon_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
// Serializes one byte as an 8N1 UART frame, CLKDIV clocks per bit.
//
// Parameters:
//   CLKDIV : clock cycles per UART bit (>= 2)
// Ports:
//   clk   in   system clock
//   rst   in   synchronous reset, active-high
//   load  in   accept data and start a frame (only honoured in IDLE)
//   data  in   byte to send, LSB first
//   tx    out  serial line, idle high, driven from a flop
//   busy  out  high while START/DATA/STOP is in progress
//   done  out  one-cycle pulse in the last cycle of the stop bit
// ---------------------------------------------------------------------------
module uart_tx_frame
    import micon_uart_pkg::*;
#(
    parameter int CLKDIV = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int BW = $clog2(CLKDIV);
    localparam int CW = $clog2(UART_DATA_BITS);

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_START = 2'(START);
    localparam logic [1:0] ST_DATA  = 2'(DATA);
    localparam logic [1:0] ST_STOP  = 2'(STOP);

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKDIV - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(UART_DATA_BITS - 1);

    logic [1:0]    state;
    logic [BW-1:0] baud_cnt;
    logic [CW-1:0] bit_cnt;
    logic [7:0]    shreg;
    logic          baud_end;

    assign baud_end = (baud_cnt == BAUD_LAST);
    assign done     = (state == ST_STOP) && baud_end;

    // Frame sequencer. The next tx level is registered one edge before the
    // bit it belongs to begins, so every bit lasts exactly CLKDIV cycles
    // and the line never sees a combinational glitch. The shift register
    // always presents the next data bit in shreg[0].
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        shreg    <= data;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        tx       <= shreg[0];
                        shreg    <= {1'b0, shreg[7:1]};
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            tx      <= 1'b1;
                            state   <= ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART TX line between N_REQ requesters with round-robin grant.
//
// Parameters:
//   N_REQ  : number of requesters (1..8)
//   CLKDIV : clock cycles per UART bit (>= 2)
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   req_valid  in   [N_REQ]    requester i has a byte pending
//   req_data   in   [8*N_REQ]  byte of requester i at [8i+7:8i]
//   req_lock   in   [N_REQ]    only with UART_TX_ARB_LOCK_EN: hold grant
//   req_ready  out  [N_REQ]    one-hot, combinational, only while idle
//   tx         out  serial line, idle high
//   busy       out  frame in flight
//   grant_id   out  index of the last granted requester
//
// Build option: define UART_TX_ARB_LOCK_EN to add req_lock. While the last
// granted requester holds its lock, only it may be granted and the
// round-robin pointer is not advanced, so multi-byte messages stay intact.
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import micon_uart_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int CLKDIV = 12
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [N_REQ-1:0]                           req_valid,
    input  logic [8*N_REQ-1:0]                         req_data,
`ifdef UART_TX_ARB_LOCK_EN
    input  logic [N_REQ-1:0]                           req_lock,
`endif
    output logic [N_REQ-1:0]                           req_ready,
    output logic                                       tx,
    output logic                                       busy,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] grant_id
);

    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] sel;
    logic [IDW-1:0] next_ptr;
    logic           found;
    logic           line_active;
    logic           handshake;
    logic           frame_done;
    logic [7:0]     load_data;
    int             idx;

    // Pick the first valid requester at or above the pointer, wrapping.
    // With the lock option, a locked last-grantee owns the line outright,
    // even while its own valid is low, so nobody else can slip in between
    // the bytes of its message.
    always_comb begin
        idx   = 0;
        sel   = '0;
        found = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = (int'(rr_ptr) + off) % N_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                sel   = IDW'(idx);
            end
        end
`ifdef UART_TX_ARB_LOCK_EN
        if (req_lock[grant_id]) begin
            found = req_valid[grant_id];
            sel   = grant_id;
        end
`endif
        req_ready = '0;
        if (!line_active && found) begin
            req_ready[sel] = 1'b1;
        end
    end

    assign handshake = |(req_valid & req_ready);
    assign load_data = req_data[{sel, 3'b000} +: 8];
    assign next_ptr  = (sel == LAST_ID) ? '0 : sel + 1'b1;

    // Grant bookkeeping. line_active mirrors the frame engine's busy flag
    // (set on the handshake edge, cleared on the stop-bit done edge) so the
    // ready decode does not depend on the frame's internal state encoding.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            grant_id    <= '0;
            line_active <= 1'b0;
        end else begin
            if (frame_done) begin
                line_active <= 1'b0;
            end
            if (handshake) begin
                line_active <= 1'b1;
                grant_id    <= sel;
`ifdef UART_TX_ARB_LOCK_EN
                if (!req_lock[sel]) begin
                    rr_ptr <= next_ptr;
                end
`else
                rr_ptr <= next_ptr;
`endif
            end
        end
    end

    uart_tx_frame #(
        .CLKDIV (CLKDIV)
    ) u_frame (
        .clk  (clk),
        .rst  (rst),
        .load (handshake),
        .data (load_data),
        .tx   (tx),
        .busy (busy),
        .done (frame_done)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter (N_REQ=2, CLKDIV=12). A small UART
// receiver built from cycle stamps decodes each frame relative to the
// handshake cycle. Define UART_TX_ARB_LOCK_EN to also exercise req_lock.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N_REQ  = 2;
    localparam int CLKDIV = 12;
    localparam int PITCH  = 10 * CLKDIV + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic        tx;
    logic        busy;
    logic [0:0]  grant_id;
`ifdef UART_TX_ARB_LOCK_EN
    logic [1:0]  req_lock;
`endif

    int cyc        = 0;
    int compared   = 0;
    int mismatched = 0;

    uart_tx_arbiter #(
        .N_REQ  (N_REQ),
        .CLKDIV (CLKDIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
`ifdef UART_TX_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .req_ready (req_ready),
        .tx        (tx),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    // Free-running clock and a cycle counter; at a negedge, cyc equals the
    // index of the cycle currently in progress.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [15:0] data);
        req_valid = valid;
        req_data  = data;
    endtask

    task automatic atCycle(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits (bounded) for a valid&&ready cycle; returns its cycle stamp.
    task automatic waitHandshake(input int expIdx, input string tag, output int stamp);
        bit found;
        found = 1'b0;
        #1;
        for (int n = 0; n < 400 && !found; n++) begin
            if (|(req_valid & req_ready)) begin
                found = 1'b1;
            end else begin
                @(negedge clk);
                #1;
            end
        end
        stamp = cyc;
        checkOutput({tag, "_handshake_seen"}, 32'(found), 32'd1);
        if (found) begin
            checkOutput({tag, "_ready"}, 32'(req_ready), 32'(2'b01 << expIdx));
        end
    endtask

    // Decodes one frame whose handshake happened in cycle stamp.
    task automatic rxByte(input int stamp, input string tag, input logic [7:0] expByte);
        logic [7:0] b;
        bit         lowOk;
        lowOk = 1'b1;
        b     = '0;
        for (int c = 1; c <= CLKDIV; c++) begin
            atCycle(stamp + c);
            if (tx !== 1'b0) lowOk = 1'b0;
        end
        checkOutput({tag, "_start_low"}, 32'(lowOk), 32'd1);
        for (int k = 0; k < 8; k++) begin
            atCycle(stamp + 1 + (k + 1) * CLKDIV + CLKDIV / 2);
            b[k] = tx;
        end
        checkOutput({tag, "_byte"}, 32'(b), 32'(expByte));
        atCycle(stamp + 1 + 9 * CLKDIV + CLKDIV / 2);
        checkOutput({tag, "_stop_high"}, 32'(tx), 32'd1);
    endtask

    initial begin
        int  t;
        int  t2;
        int  prev;
        bit  idleOk;
        bit  quiet;

        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
`ifdef UART_TX_ARB_LOCK_EN
        req_lock  = '0;
`endif
        $display("[TB] start");

        // Reset state, then 50 idle cycles.
        doReset();
        checkOutput("rst_tx", 32'(tx), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_grant", 32'(grant_id), 32'd0);
        idleOk = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || req_ready !== 2'b00) idleOk = 1'b0;
        end
        checkOutput("idle_50", 32'(idleOk), 32'd1);

        // Single byte 'A' from requester 0.
        applyStimulus(2'b01, {8'h00, 8'h41});
        waitHandshake(0, "A", t);
        atCycle(t + 1);
        checkOutput("A_grant", 32'(grant_id), 32'd0);
        applyStimulus(2'b00, 16'h0000);
        rxByte(t, "A", 8'h41);
        atCycle(t + 120);
        checkOutput("A_busy_last", 32'(busy), 32'd1);
        atCycle(t + 121);
        checkOutput("A_busy_fall", 32'(busy), 32'd0);

        // Both valid continuously: strict alternation, 121-cycle pitch.
        doReset();
        applyStimulus(2'b11, {8'h31, 8'h30});
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            waitHandshake(k % 2, "RR", t);
            if (k > 0) checkOutput("RR_pitch", 32'(t - prev), 32'(PITCH));
            prev = t;
            atCycle(t + 1);
            checkOutput("RR_grant", 32'(grant_id), 32'(k % 2));
            if (k == 3) applyStimulus(2'b00, 16'h0000);
            rxByte(t, "RR", 8'h30 + 8'(k % 2));
        end
        atCycle(t + 121);

        // Requester 1 arrives mid-frame of requester 0: waits for idle.
        applyStimulus(2'b01, {8'h6B, 8'h52});
        waitHandshake(0, "MID0", t);
        atCycle(t + 1);
        applyStimulus(2'b10, {8'h6B, 8'h00});
        quiet = 1'b1;
        for (int c = 2; c <= 120; c++) begin
            atCycle(t + c);
            if (req_ready !== 2'b00) quiet = 1'b0;
        end
        checkOutput("MID_ready_quiet", 32'(quiet), 32'd1);
        waitHandshake(1, "MID1", t2);
        checkOutput("MID_gap", 32'(t2 - t), 32'(PITCH));
        atCycle(t2 + 1);
        applyStimulus(2'b00, 16'h0000);
        rxByte(t2, "MID1", 8'h6B);
        atCycle(t2 + 121);

        // Reset in the middle of a frame, then a clean frame.
        applyStimulus(2'b10, {8'h55, 8'h00});
        waitHandshake(1, "ABRT", t);
        atCycle(t + 1);
        applyStimulus(2'b00, 16'h0000);
        atCycle(t + 49);
        checkOutput("ABRT_grant_pre", 32'(grant_id), 32'd1);
        checkOutput("ABRT_busy_pre", 32'(busy), 32'd1);
        atCycle(t + 50);
        checkOutput("ABRT_tx_pre", 32'(tx), 32'd0);
        rst = 1'b1;
        atCycle(t + 51);
        rst = 1'b0;
        checkOutput("ABRT_tx_post", 32'(tx), 32'd1);
        checkOutput("ABRT_busy_post", 32'(busy), 32'd0);
        checkOutput("ABRT_grant_post", 32'(grant_id), 32'd0);
        applyStimulus(2'b01, {8'h00, 8'h5A});
        waitHandshake(0, "POST", t);
        atCycle(t + 1);
        applyStimulus(2'b00, 16'h0000);
        rxByte(t, "POST", 8'h5A);
        atCycle(t + 121);

`ifdef UART_TX_ARB_LOCK_EN
        // Locked requester 0 sends "AB" while requester 1 waits with 'z'.
        doReset();
        req_lock = 2'b01;
        applyStimulus(2'b11, {8'h7A, 8'h41});
        waitHandshake(0, "LK_A", t);
        atCycle(t + 1);
        applyStimulus(2'b11, {8'h7A, 8'h42});
        rxByte(t, "LK_A", 8'h41);
        waitHandshake(0, "LK_B", t);
        atCycle(t + 1);
        req_lock = 2'b00;
        applyStimulus(2'b10, {8'h7A, 8'h00});
        rxByte(t, "LK_B", 8'h42);
        waitHandshake(1, "LK_z", t);
        atCycle(t + 1);
        applyStimulus(2'b00, 16'h0000);
        rxByte(t, "LK_z", 8'h7A);
        atCycle(t + 121);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
